cplink_fifo_bridge: RTL and testbench
=====================================

# cplink_fifo_bridge

Parametrised, synchronous replacement for the discrete 40105-based CPC↔Pi link buffer. It holds two independent FIFOs: host→slave (h2s) and slave→host (s2h). The CPC side has a decoded two-register I/O window (data, status/control) and the Pi side has strobe-driven push/pop. It adds per-channel soft reset, sticky overflow/underflow flags, fill levels and a host interrupt, none of which the discrete build had. It sits between the CPC bus decode logic and the Pi GPIO level shifters in the CPLD/FPGA build of the link.

## Interface
Parameters:
- DATA_W, 8, data width of both FIFOs; minimum 4.
- DEPTH, 16, entries per FIFO; power of two, 2..256.
- LEVEL_W, $clog2(DEPTH+1), width of the level outputs; derived, not overridden.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- host_sel  in  1  I/O window decoded (IOREQ and address match), qualifies host strobes.
- host_a0  in  1  0 = data register, 1 = status/control register.
- host_wr  in  1  one-cycle write strobe, already synchronised.
- host_rd  in  1  one-cycle read strobe, already synchronised.
- host_din  in  DATA_W  host write data.
- host_dout  out  DATA_W  host read data.
- host_oe  out  1  drive enable for host data bus.
- host_irq  out  1  interrupt request to host.
- slave_wr  in  1  one-cycle push strobe into s2h.
- slave_rd  in  1  one-cycle pop strobe from h2s.
- slave_din  in  DATA_W  s2h write data.
- slave_dout  out  DATA_W  h2s head entry (fall-through).
- slave_dir  out  1  s2h not full.
- slave_dor  out  1  h2s not empty.
- h2s_level  out  LEVEL_W  h2s occupancy.
- s2h_level  out  LEVEL_W  s2h occupancy.

## Operation
Host accesses:
- hw = host_sel & host_wr; hr = host_sel & host_rd.
- hw & !a0: push host_din into h2s.
- hr & !a0: pop s2h; host_dout = s2h head.
- hw & a0, control byte:
  - bit0: soft-reset h2s.
  - bit1: soft-reset s2h.
  - bit2: irq_en. This bit is written on every control write.
- hr & a0, status byte:
  - bit0: s2h not empty.
  - bit1: h2s not full.
  - bit2: h2s overflow, sticky.
  - bit3: s2h underflow, sticky.
  - bits DATA_W-1:4: zero.
- host_oe = hr, combinational. host_dout = status when a0=1, otherwise s2h head. host_dout is 0 when hr = 0.
- host_irq = irq_en & s2h not empty.

FIFO rules, identical for both channels:
- Push when full with no pop in the same cycle: data dropped, overflow flag set, level unchanged.
- Push and pop in the same cycle while full: both succeed, level unchanged.
- Pop when empty: ignored, underflow flag set, outputs unchanged.
- Push and pop in the same cycle while empty: push succeeds, pop counts as underflow.
- Pointers wrap modulo DEPTH. Level is tracked explicitly, 0..DEPTH.
- Soft reset clears that channel's pointers, level and both sticky flags. It beats any push or pop on that channel in the same cycle. The other channel is unaffected.
- Sticky flags are cleared only by reset_b or by a soft reset of the owning channel. h2s overflow is also set by host pushes; s2h underflow is also set by host pops. Slave-side overflow and underflow set the same per-channel flags.

## Timing
- Reset (reset_b low):
  - Both FIFOs empty, levels 0, flags 0, irq_en 0.
  - slave_dor = 0, slave_dir = 1, host_irq = 0, host_oe = 0, host_dout = 0, slave_dout = 0.
- Push at edge N: the entry is visible at the head, dor/irq asserted and level updated from edge N+1.
- Pop at edge N: the next entry or the new flags are visible from edge N+1.
- Fall-through latency on an empty FIFO is 1 cycle. Throughput is one push and one pop per cycle per channel.
- Host read data and status are combinational from the registered state, valid during the same cycle as hr. The pop takes effect at the end of that cycle.
- Soft reset takes effect at the edge that samples the control write.
- Asserting reset_b mid-transfer discards all contents immediately, with no clock required.

## Structure
- Package cplink_pkg holds:
  - the status bit index constants (ST_S2H_DOR=0, ST_H2S_DIR=1, ST_H2S_OVF=2, ST_S2H_UDF=3);
  - the control bit index constants (CT_RST_H2S=0, CT_RST_S2H=1, CT_IRQ_EN=2);
  - the register select constants (REG_DATA=0, REG_CTRL=1).
- Sub-module cplink_sync_fifo (DATA_W, DEPTH) is instantiated twice. It contains memory, pointers, level, fall-through head, soft-clear input and the overflow/underflow flags.
- The top level holds host decode, the irq_en register, status muxing and the irq logic.

## Test plan
- Reset: release reset_b → status = 0x02, both levels 0, host_irq 0, slave_dir 1.
- h2s overflow: 17 host data writes with DEPTH=16 → level 16, status bit2 = 1. Then 16 slave_rd → data order 1..16 with 17th lost, slave_dor = 0.
- s2h underflow and irq: write control 0x04, slave_wr 0xA5 → host_irq 1 the next cycle. Host reads data 0xA5 → host_irq 0. An extra host read → status bit3 = 1.
- Full with simultaneous push and pop: s2h full, slave_wr and host data read in the same cycle → level stays 16, no overflow, FIFO order preserved.
- Soft reset isolation: both FIFOs holding 5 entries, write control 0x01 → h2s_level 0 and its flags clear, s2h_level 5. A push in the same cycle as the reset is discarded.
- Async reset mid-burst: drop reset_b between clock edges during alternating pushes → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/cplink_pkg.sv
// Shared register map for the CPC<->Pi link FIFO bridge.
package cplink_pkg;

  // Status register bit positions
  localparam int unsigned ST_S2H_DOR = 0;
  localparam int unsigned ST_H2S_DIR = 1;
  localparam int unsigned ST_H2S_OVF = 2;
  localparam int unsigned ST_S2H_UDF = 3;

  // Control register bit positions
  localparam int unsigned CT_RST_H2S = 0;
  localparam int unsigned CT_RST_S2H = 1;
  localparam int unsigned CT_IRQ_EN  = 2;

  // Host register select (host_a0)
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

endpackage

// File: rtl/cplink_sync_fifo.sv
// Single-clock fall-through FIFO with explicit level, soft clear and sticky
// overflow/underflow flags.
module cplink_sync_fifo
  import cplink_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [DATA_W-1:0]  din,
  output logic [DATA_W-1:0]  dout,
  output logic               empty,
  output logic               full,
  output logic [LEVEL_W-1:0] level,
  output logic               ovf,
  output logic               udf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic               ovf_q;
  logic               udf_q;
  logic               do_push;
  logic               do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LEVEL_W'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push lands in
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
      if (push & full & ~pop) ovf_q <= 1'b1;
      if (pop & empty)        udf_q <= 1'b1;
    end
  end

  // Storage needs no reset: the level gates visibility of stale entries
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = level_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: rtl/cplink_fifo_bridge.sv
// CPC<->Pi link buffer: host register window and Pi strobes in front of two
// independent FIFOs, with status, soft reset and host interrupt.
module cplink_fifo_bridge
  import cplink_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic               host_sel,
  input  logic               host_a0,
  input  logic               host_wr,
  input  logic               host_rd,
  input  logic [DATA_W-1:0]  host_din,
  output logic [DATA_W-1:0]  host_dout,
  output logic               host_oe,
  output logic               host_irq,
  input  logic               slave_wr,
  input  logic               slave_rd,
  input  logic [DATA_W-1:0]  slave_din,
  output logic [DATA_W-1:0]  slave_dout,
  output logic               slave_dir,
  output logic               slave_dor,
  output logic [LEVEL_W-1:0] h2s_level,
  output logic [LEVEL_W-1:0] s2h_level
);

  logic              hw;
  logic              hr;
  logic              ctrl_wr;
  logic              h2s_clr;
  logic              s2h_clr;
  logic              irq_en;
  logic              h2s_empty;
  logic              h2s_full;
  logic              h2s_ovf;
  logic              h2s_udf;
  logic              s2h_empty;
  logic              s2h_full;
  logic              s2h_ovf;
  logic              s2h_udf;
  logic [DATA_W-1:0] s2h_head;
  logic [DATA_W-1:0] status;
  logic              unused_flags;

  // Host strobe decode
  assign hw      = host_sel & host_wr;
  assign hr      = host_sel & host_rd;
  assign ctrl_wr = hw & (host_a0 == REG_CTRL);
  assign h2s_clr = ctrl_wr & host_din[CT_RST_H2S];
  assign s2h_clr = ctrl_wr & host_din[CT_RST_S2H];

  cplink_sync_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_h2s (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (h2s_clr),
    .push    (hw & (host_a0 == REG_DATA)),
    .pop     (slave_rd),
    .din     (host_din),
    .dout    (slave_dout),
    .empty   (h2s_empty),
    .full    (h2s_full),
    .level   (h2s_level),
    .ovf     (h2s_ovf),
    .udf     (h2s_udf)
  );

  cplink_sync_fifo #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_s2h (
    .clk     (clk),
    .reset_b (reset_b),
    .clr     (s2h_clr),
    .push    (slave_wr),
    .pop     (hr & (host_a0 == REG_DATA)),
    .din     (slave_din),
    .dout    (s2h_head),
    .empty   (s2h_empty),
    .full    (s2h_full),
    .level   (s2h_level),
    .ovf     (s2h_ovf),
    .udf     (s2h_udf)
  );

  // irq_en is rewritten by every control write
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      irq_en <= 1'b0;
    end else if (ctrl_wr) begin
      irq_en <= host_din[CT_IRQ_EN];
    end
  end

  always_comb begin
    status             = '0;
    status[ST_S2H_DOR] = ~s2h_empty;
    status[ST_H2S_DIR] = ~h2s_full;
    status[ST_H2S_OVF] = h2s_ovf;
    status[ST_S2H_UDF] = s2h_udf;
  end

  // Bus drives only while a read is decoded
  always_comb begin
    host_dout = '0;
    if (hr) begin
      host_dout = (host_a0 == REG_CTRL) ? status : s2h_head;
    end
  end

  assign host_oe   = hr;
  assign host_irq  = irq_en & ~s2h_empty;
  assign slave_dir = ~s2h_full;
  assign slave_dor = ~h2s_empty;

  // These flags are not mapped into the host status register
  assign unused_flags = &{1'b0, s2h_ovf, h2s_udf};

endmodule

// File: tb/tb_cplink_fifo_bridge.sv
// Bench for cplink_fifo_bridge: vector table plus queue-based scoreboard.
module tb_cplink_fifo_bridge;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;

  logic          clk;
  logic          reset_b;
  logic          host_sel;
  logic          host_a0;
  logic          host_wr;
  logic          host_rd;
  logic [DW-1:0] host_din;
  logic [DW-1:0] host_dout;
  logic          host_oe;
  logic          host_irq;
  logic          slave_wr;
  logic          slave_rd;
  logic [DW-1:0] slave_din;
  logic [DW-1:0] slave_dout;
  logic          slave_dir;
  logic          slave_dor;
  logic [LW-1:0] h2s_level;
  logic [LW-1:0] s2h_level;

  cplink_fifo_bridge #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .host_sel   (host_sel),
    .host_a0    (host_a0),
    .host_wr    (host_wr),
    .host_rd    (host_rd),
    .host_din   (host_din),
    .host_dout  (host_dout),
    .host_oe    (host_oe),
    .host_irq   (host_irq),
    .slave_wr   (slave_wr),
    .slave_rd   (slave_rd),
    .slave_din  (slave_din),
    .slave_dout (slave_dout),
    .slave_dir  (slave_dir),
    .slave_dor  (slave_dor),
    .h2s_level  (h2s_level),
    .s2h_level  (s2h_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] hq[$];
  logic [DW-1:0] sq[$];
  bit            m_ovf;
  bit            m_udf;
  bit            m_irq_en;

  // Values sampled during the last cycle, before its clock edge
  logic [DW-1:0] got_hdout;
  logic [DW-1:0] got_sdout;
  logic          got_oe;

  typedef struct {
    logic          sel, a0, wr, rd;
    logic [DW-1:0] din;
    logic          swr, srd;
    logic [DW-1:0] sdin;
    logic [DW-1:0] e_hdout;
    logic          e_oe;
    logic [DW-1:0] e_sdout;
    logic [LW-1:0] e_hl, e_sl;
    logic          e_irq;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] status_exp();
    logic [DW-1:0] s;
    s    = '0;
    s[0] = (sq.size() != 0);
    s[1] = (hq.size() < DEPTH);
    s[2] = m_ovf;
    s[3] = m_udf;
    return s;
  endfunction

  task automatic model_reset();
    hq.delete();
    sq.delete();
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    m_irq_en = 1'b0;
  endtask

  // One clock cycle of stimulus, checked against the model before and after the edge
  task automatic cyc(input logic sel, input logic a0, input logic wr, input logic rd,
                     input logic [DW-1:0] din, input logic swr, input logic srd,
                     input logic [DW-1:0] sdin);
    logic hw, hr;
    bit   clr_h, clr_s, can_push;
    host_sel = sel; host_a0 = a0; host_wr = wr; host_rd = rd; host_din = din;
    slave_wr = swr; slave_rd = srd; slave_din = sdin;
    #1;
    got_hdout = host_dout;
    got_oe    = host_oe;
    got_sdout = slave_dout;
    hw = sel & wr;
    hr = sel & rd;
    chk("host_oe", 32'(host_oe), 32'(hr));
    if (hr && a0)  chk("status", 32'(host_dout), 32'(status_exp()));
    else if (hr)   chk("host_data", 32'(host_dout), 32'(sq.size() != 0 ? sq[0] : 8'h00));
    else           chk("host_dout_idle", 32'(host_dout), 32'h0);
    chk("slave_dout", 32'(slave_dout), 32'(hq.size() != 0 ? hq[0] : 8'h00));

    clr_h = hw && a0 && din[0];
    clr_s = hw && a0 && din[1];
    if (hw && a0) m_irq_en = din[2];
    if (clr_h) begin
      hq.delete(); m_ovf = 1'b0;
    end else begin
      can_push = hw && !a0 && (hq.size() < DEPTH || srd);
      if (hw && !a0 && hq.size() == DEPTH && !srd) m_ovf = 1'b1;
      if (srd && hq.size() != 0) void'(hq.pop_front());
      if (can_push) hq.push_back(din);
    end
    if (clr_s) begin
      sq.delete(); m_udf = 1'b0;
    end else begin
      can_push = swr && (sq.size() < DEPTH || (hr && !a0));
      if (hr && !a0 && sq.size() == 0) m_udf = 1'b1;
      if (hr && !a0 && sq.size() != 0) void'(sq.pop_front());
      if (can_push) sq.push_back(sdin);
    end

    @(posedge clk);
    #1;
    chk("h2s_level", 32'(h2s_level), 32'(hq.size()));
    chk("s2h_level", 32'(s2h_level), 32'(sq.size()));
    chk("slave_dor", 32'(slave_dor), 32'(hq.size() != 0));
    chk("slave_dir", 32'(slave_dir), 32'(sq.size() < DEPTH));
    chk("host_irq", 32'(host_irq), 32'(m_irq_en && sq.size() != 0));
    host_sel = 1'b0; host_wr = 1'b0; host_rd = 1'b0;
    slave_wr = 1'b0; slave_rd = 1'b0;
  endtask

  task automatic hwrite(input logic a0, input logic [DW-1:0] d);
    cyc(1'b1, a0, 1'b1, 1'b0, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic hread(input logic a0);
    cyc(1'b1, a0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic swrite(input logic [DW-1:0] d);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, d);
  endtask

  task automatic sread();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
  endtask

  initial begin
    //          sel   a0    wr    rd    din    swr   srd   sdin   hdout  oe    sdout  hl    sl    irq
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 5'd1, 5'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 8'h11, 5'd1, 5'd1, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 8'h11, 5'd1, 5'd1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 5'd1, 5'd1, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 8'h11, 5'd1, 5'd0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h11, 5'd0, 5'd0, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h0A, 1'b1, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h06, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 5'd0, 5'd0, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h00, 5'd0, 5'd0, 1'b0};

    reset_b = 1'b0;
    host_sel = 1'b0; host_a0 = 1'b0; host_wr = 1'b0; host_rd = 1'b0; host_din = '0;
    slave_wr = 1'b0; slave_rd = 1'b0; slave_din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst slave_dir", 32'(slave_dir), 32'h1);
    chk("rst slave_dor", 32'(slave_dor), 32'h0);
    chk("rst host_irq", 32'(host_irq), 32'h0);
    chk("rst h2s_level", 32'(h2s_level), 32'h0);
    chk("rst s2h_level", 32'(s2h_level), 32'h0);
    chk("rst slave_dout", 32'(slave_dout), 32'h0);
    #1 reset_b = 1'b1;
    @(posedge clk);
    #1;

    // Register-level vector table
    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].sel, vt[i].a0, vt[i].wr, vt[i].rd, vt[i].din, vt[i].swr, vt[i].srd, vt[i].sdin);
      chk($sformatf("vec%0d hdout", i), 32'(got_hdout), 32'(vt[i].e_hdout));
      chk($sformatf("vec%0d oe", i), 32'(got_oe), 32'(vt[i].e_oe));
      chk($sformatf("vec%0d sdout", i), 32'(got_sdout), 32'(vt[i].e_sdout));
      chk($sformatf("vec%0d h2s_level", i), 32'(h2s_level), 32'(vt[i].e_hl));
      chk($sformatf("vec%0d s2h_level", i), 32'(s2h_level), 32'(vt[i].e_sl));
      chk($sformatf("vec%0d irq", i), 32'(host_irq), 32'(vt[i].e_irq));
    end

    // h2s overflow: 17 writes, 17th lost
    for (int v = 1; v <= 17; v++) hwrite(1'b0, 8'(v));
    chk("ovf h2s_level", 32'(h2s_level), 32'd16);
    hread(1'b1);
    chk("ovf status bit2", 32'(got_hdout[2]), 32'h1);
    for (int v = 1; v <= 16; v++) begin
      sread();
      chk("ovf drain order", 32'(got_sdout), 32'(v));
    end
    chk("ovf drained dor", 32'(slave_dor), 32'h0);

    // irq and s2h underflow
    hwrite(1'b1, 8'h04);
    swrite(8'hA5);
    chk("irq set", 32'(host_irq), 32'h1);
    hread(1'b0);
    chk("irq read data", 32'(got_hdout), 32'hA5);
    chk("irq cleared", 32'(host_irq), 32'h0);
    hread(1'b0);
    hread(1'b1);
    chk("udf status bit3", 32'(got_hdout[3]), 32'h1);

    // s2h full with simultaneous push and pop
    hwrite(1'b1, 8'h06);
    for (int i = 0; i < 16; i++) swrite(8'(8'h40 + i));
    chk("s2h full dir", 32'(slave_dir), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hEE);
    chk("full pp data", 32'(got_hdout), 32'h40);
    chk("full pp level", 32'(s2h_level), 32'd16);
    for (int i = 1; i < 16; i++) begin
      hread(1'b0);
      chk("full pp order", 32'(got_hdout), 32'(8'h40 + i));
    end
    hread(1'b0);
    chk("full pp last", 32'(got_hdout), 32'hEE);
    hread(1'b1);
    chk("full pp no udf", 32'(got_hdout[3]), 32'h0);

    // Soft reset isolation (h2s overflow still sticky from earlier)
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 1'b1, 1'b0, 8'(8'h70 + i));
    hread(1'b1);
    chk("iso pre ovf", 32'(got_hdout[2]), 32'h1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'h00);
    chk("iso h2s_level", 32'(h2s_level), 32'd0);
    chk("iso s2h_level", 32'(s2h_level), 32'd5);
    hread(1'b1);
    chk("iso ovf clear", 32'(got_hdout[2]), 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h06, 1'b1, 1'b0, 8'h99);
    chk("iso push dropped", 32'(s2h_level), 32'd0);

    // h2s full with simultaneous push and pop, then true overflow
    for (int i = 0; i < 16; i++) hwrite(1'b0, 8'(8'h80 + i));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b1, 8'h00);
    chk("h2s pp head", 32'(got_sdout), 32'h80);
    chk("h2s pp level", 32'(h2s_level), 32'd16);
    hread(1'b1);
    chk("h2s pp no ovf", 32'(got_hdout[2]), 32'h0);
    hwrite(1'b0, 8'hF1);
    hread(1'b1);
    chk("h2s ovf set", 32'(got_hdout[2]), 32'h1);

    // Async reset mid-burst
    swrite(8'h33);
    chk("pre-reset irq", 32'(host_irq), 32'h1);
    for (int i = 0; i < 3; i++) begin
      if (i % 2 == 0) sread();
      else            swrite(8'(8'hC0 + i));
    end
    host_sel = 1'b1; host_a0 = 1'b0; host_wr = 1'b1; host_din = 8'hD0;
    #2 reset_b = 1'b0;
    #1;
    chk("arst h2s_level", 32'(h2s_level), 32'd0);
    chk("arst s2h_level", 32'(s2h_level), 32'd0);
    chk("arst dor", 32'(slave_dor), 32'h0);
    chk("arst dir", 32'(slave_dir), 32'h1);
    chk("arst irq", 32'(host_irq), 32'h0);
    chk("arst oe", 32'(host_oe), 32'h0);
    chk("arst hdout", 32'(host_dout), 32'h0);
    chk("arst sdout", 32'(slave_dout), 32'h0);
    host_sel = 1'b0; host_wr = 1'b0;
    model_reset();
    @(posedge clk);
    #3 reset_b = 1'b1;
    @(posedge clk);
    #1;
    hread(1'b1);
    chk("post-reset status", 32'(got_hdout), 32'h02);
    swrite(8'h44);
    chk("post-reset irq_en clear", 32'(host_irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
